// File: rtl/axil_mem_loader_pkg.sv
// Shared types and constants for the AXI4-Lite memory loader.
package axil_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RESP
    } ld_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] FULL_STRB   = 4'hF;

    // Write-data beat as held between W acceptance and the memory write.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_beat_t;

    localparam int unsigned W_BEAT_W = $bits(w_beat_t);

endpackage

// File: rtl/axil_mem_loader_if.sv
// AXI4-Lite write channel bundle (AW, W, B) for the memory loader.
interface axil_mem_loader_if;

    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_awready, s_wready, s_bresp, s_bvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_awready, s_wready, s_bresp, s_bvalid
    );

endinterface

// File: rtl/axil_hold_reg.sv
// One-entry holding register: captures a payload on push, empties on clear.
module axil_hold_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         full,
    output logic [W-1:0] dout,
    output logic         ready_c
);

    assign ready_c = ~full;

    // Clear wins over push; push is ignored while an entry is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push && !full) begin
            full <= 1'b1;
            dout <= din;
        end
    end

endmodule

// File: rtl/axil_mem_loader.sv
// AXI4-Lite write-only slave issuing single-cycle word writes to a memory load port.
// Optional AXIL_MEM_LOADER_WCOUNT_EN adds a saturating write counter and sticky error flag.
module axil_mem_loader
    import axil_mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 512,
    parameter int unsigned MEM_AW    = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    axil_mem_loader_if.slave      bus,
    output logic                  axi_mem_w,
    output logic [MEM_AW-1:0]     axi_mem_addr,
    output logic [31:0]           axi_mem_data
`ifdef AXIL_MEM_LOADER_WCOUNT_EN
    ,
    output logic [15:0]           wr_count,
    output logic                  err_seen
`endif
);

    localparam int unsigned ADDR_W = 32;

    ld_state_t             state;
    logic                  aw_full;
    logic                  w_full;
    logic                  aw_ready_c;
    logic                  w_ready_c;
    logic                  aw_push;
    logic                  w_push;
    logic                  aw_have;
    logic                  w_have;
    logic                  clear;
    logic [ADDR_W-1:0]     aw_q;
    logic [W_BEAT_W-1:0]   w_raw;
    w_beat_t               w_in;
    w_beat_t               w_q;
    logic [ADDR_W-1:0]     offset;
    logic                  legal_c;

    assign aw_push = bus.s_awvalid & bus.s_awready & aw_ready_c;
    assign w_push  = bus.s_wvalid & bus.s_wready & w_ready_c;
    assign clear   = (state == WRITE);

    assign w_in.data = bus.s_wdata;
    assign w_in.strb = bus.s_wstrb;

    axil_hold_reg #(.W(ADDR_W)) u_aw_hold (
        .clk     (clk),
        .reset   (reset),
        .push    (aw_push),
        .clear   (clear),
        .din     (bus.s_awaddr),
        .full    (aw_full),
        .dout    (aw_q),
        .ready_c (aw_ready_c)
    );

    axil_hold_reg #(.W(W_BEAT_W)) u_w_hold (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .clear   (clear),
        .din     (w_in),
        .full    (w_full),
        .dout    (w_raw),
        .ready_c (w_ready_c)
    );

    assign w_q = w_beat_t'(w_raw);

    // Includes this cycle's handshake so a same-cycle AW+W pair moves straight to WRITE.
    assign aw_have = aw_full | aw_push;
    assign w_have  = w_full | w_push;

    // Underflow is caught by the explicit compare; the wrapped offset is only trusted after it.
    assign offset  = aw_q - BASE_ADDR;
    assign legal_c = (aw_q >= BASE_ADDR)
                   && ((offset >> 2) < ADDR_W'(MEM_WORDS))
                   && (aw_q[1:0] == 2'b00)
                   && (w_q.strb == FULL_STRB);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.s_awready <= 1'b0;
            bus.s_wready  <= 1'b0;
            bus.s_bvalid  <= 1'b0;
            bus.s_bresp   <= RESP_OKAY;
            axi_mem_w     <= 1'b0;
            axi_mem_addr  <= '0;
            axi_mem_data  <= '0;
        end else begin
            axi_mem_w <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_have && w_have) begin
                        state         <= WRITE;
                        bus.s_awready <= 1'b0;
                        bus.s_wready  <= 1'b0;
                    end else begin
                        bus.s_awready <= ~aw_have;
                        bus.s_wready  <= ~w_have;
                    end
                end
                WRITE: begin
                    axi_mem_w <= legal_c;
                    if (legal_c) begin
                        axi_mem_addr <= MEM_AW'(offset >> 2);
                        axi_mem_data <= w_q.data;
                    end
                    bus.s_bresp <= legal_c ? RESP_OKAY : RESP_SLVERR;
                    state       <= RESP;
                end
                RESP: begin
                    // One cycle after the memory pulse, then hold until accepted.
                    if (!bus.s_bvalid) begin
                        bus.s_bvalid <= 1'b1;
                    end else if (bus.s_bready) begin
                        bus.s_bvalid  <= 1'b0;
                        bus.s_awready <= 1'b1;
                        bus.s_wready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AXIL_MEM_LOADER_WCOUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
            err_seen <= 1'b0;
        end else begin
            if (axi_mem_w && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (bus.s_bvalid && (bus.s_bresp == RESP_SLVERR)) begin
                err_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axil_mem_loader.sv
// Directed plus randomized self-checking bench for axil_mem_loader against a word-level memory model.
module tb_axil_mem_loader;
    import axil_mem_loader_pkg::*;

    localparam int unsigned MEM_WORDS = 512;
    localparam int unsigned MEM_AW    = 9;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axil_mem_loader_if bus ();

    logic              axi_mem_w;
    logic [MEM_AW-1:0] axi_mem_addr;
    logic [31:0]       axi_mem_data;
`ifdef AXIL_MEM_LOADER_WCOUNT_EN
    logic [15:0]       wr_count;
    logic              err_seen;
`endif

    axil_mem_loader #(
        .BASE_ADDR (BASE),
        .MEM_WORDS (MEM_WORDS),
        .MEM_AW    (MEM_AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .axi_mem_w    (axi_mem_w),
        .axi_mem_addr (axi_mem_addr),
        .axi_mem_data (axi_mem_data)
`ifdef AXIL_MEM_LOADER_WCOUNT_EN
        ,
        .wr_count     (wr_count),
        .err_seen     (err_seen)
`endif
    );

    int unsigned cyc = 0;
    int unsigned pulse_cnt = 0;
    int unsigned last_pulse_cyc = 0;
    logic [MEM_AW-1:0] last_addr = '0;
    logic [31:0]       last_data = '0;
    logic [31:0]       mem_obs [MEM_WORDS] = '{default: 32'h0};

    always @(posedge clk) cyc <= cyc + 1;

    // Records every memory write the DUT issues.
    always @(negedge clk) begin
        if (axi_mem_w === 1'b1) begin
            pulse_cnt      <= pulse_cnt + 1;
            last_pulse_cyc <= cyc;
            last_addr      <= axi_mem_addr;
            last_data      <= axi_mem_data;
            mem_obs[axi_mem_addr] <= axi_mem_data;
        end
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0]       mem_model [MEM_WORDS];
    logic [MEM_AW-1:0] model_addr;
    logic [31:0]       model_data;
`ifdef AXIL_MEM_LOADER_WCOUNT_EN
    int unsigned       model_wr;
    logic              model_err;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic bit legal(input logic [31:0] a, input logic [3:0] s);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off % 4 == 0) && (off / 4 < longint'(MEM_WORDS)) && (s == 4'hF);
    endfunction

    task automatic model_reset();
        model_addr = '0;
        model_data = '0;
`ifdef AXIL_MEM_LOADER_WCOUNT_EN
        model_wr  = 0;
        model_err = 1'b0;
`endif
    endtask

    // Drives AW and W with W leading by w_lead cycles (negative: AW leads); cap = cycle before capture edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int w_lead, output int unsigned cap);
        int aw_start;
        int w_start;
        bit aw_done;
        bit w_done;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        aw_done  = 1'b0;
        w_done   = 1'b0;
        cap      = cyc;
        bus.s_awaddr = a;
        bus.s_wdata  = d;
        bus.s_wstrb  = s;
        for (int t = 0; t < 60 && !(aw_done && w_done); t++) begin
            bus.s_awvalid = !aw_done && (t >= aw_start);
            bus.s_wvalid  = !w_done && (t >= w_start);
            if (w_done && !aw_done) chk("wready_while_aw_missing", 64'(bus.s_wready), 64'(0));
            if (aw_done && !w_done) chk("awready_while_w_missing", 64'(bus.s_awready), 64'(0));
            if (bus.s_awvalid && bus.s_awready) aw_done = 1'b1;
            if (bus.s_wvalid && bus.s_wready) w_done = 1'b1;
            cap = cyc;
            step();
        end
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        chk("handshake_done", 64'(aw_done && w_done), 64'(1));
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int w_lead, input int bdly);
        int unsigned cap;
        int unsigned p0;
        int unsigned word;
        bit          ok;
        logic [1:0]  er;
        ok   = legal(a, s);
        er   = ok ? RESP_OKAY : RESP_SLVERR;
        word = ok ? int'((longint'(a) - longint'(BASE)) / 4) : 0;
        p0   = pulse_cnt;
        bus.s_bready = 1'b0;
        send(a, d, s, w_lead, cap);
        for (int k = 0; k < 20 && !bus.s_bvalid; k++) step();
        chk("bvalid_latency", 64'(cyc), 64'(cap + 3));
        chk("pulse_count", 64'(pulse_cnt - p0), 64'(ok ? 1 : 0));
        if (ok) begin
            chk("pulse_latency", 64'(last_pulse_cyc), 64'(cap + 2));
            chk("mem_addr", 64'(last_addr), 64'(word));
            chk("mem_data", 64'(last_data), 64'(d));
            mem_model[word] = d;
            model_addr = MEM_AW'(word);
            model_data = d;
`ifdef AXIL_MEM_LOADER_WCOUNT_EN
            if (model_wr < 65535) model_wr++;
`endif
        end
        chk("addr_hold", 64'(axi_mem_addr), 64'(model_addr));
        chk("data_hold", 64'(axi_mem_data), 64'(model_data));
        for (int i = 0; i < bdly; i++) begin
            chk("bvalid_held", 64'(bus.s_bvalid), 64'(1));
            chk("bresp_stable", 64'(bus.s_bresp), 64'(er));
            chk("awready_in_resp", 64'(bus.s_awready), 64'(0));
            chk("wready_in_resp", 64'(bus.s_wready), 64'(0));
            step();
        end
        bus.s_bready = 1'b1;
        chk("bvalid", 64'(bus.s_bvalid), 64'(1));
        chk("bresp", 64'(bus.s_bresp), 64'(er));
        step();
        bus.s_bready = 1'b0;
        chk("bvalid_cleared", 64'(bus.s_bvalid), 64'(0));
        chk("awready_back", 64'(bus.s_awready), 64'(1));
        chk("wready_back", 64'(bus.s_wready), 64'(1));
        chk("pulse_count_final", 64'(pulse_cnt - p0), 64'(ok ? 1 : 0));
`ifdef AXIL_MEM_LOADER_WCOUNT_EN
        if (!ok) model_err = 1'b1;
        chk("wr_count", 64'(wr_count), 64'(model_wr));
        chk("err_seen", 64'(err_seen), 64'(model_err));
`endif
    endtask

    initial begin
        int unsigned cap;
        int unsigned p0;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          sel;

        for (int i = 0; i < int'(MEM_WORDS); i++) mem_model[i] = 32'h0;
        model_reset();
        bus.s_awaddr  = '0;
        bus.s_awvalid = 1'b0;
        bus.s_wdata   = '0;
        bus.s_wstrb   = '0;
        bus.s_wvalid  = 1'b0;
        bus.s_bready  = 1'b0;
        reset = 1'b1;
        step();
        step();
        chk("rst_awready", 64'(bus.s_awready), 64'(0));
        chk("rst_wready", 64'(bus.s_wready), 64'(0));
        chk("rst_bvalid", 64'(bus.s_bvalid), 64'(0));
        chk("rst_bresp", 64'(bus.s_bresp), 64'(0));
        chk("rst_mem_w", 64'(axi_mem_w), 64'(0));
        chk("rst_mem_addr", 64'(axi_mem_addr), 64'(0));
        chk("rst_mem_data", 64'(axi_mem_data), 64'(0));
`ifdef AXIL_MEM_LOADER_WCOUNT_EN
        chk("rst_wr_count", 64'(wr_count), 64'(0));
        chk("rst_err_seen", 64'(err_seen), 64'(0));
`endif
        reset = 1'b0;
        step();
        chk("awready_after_reset", 64'(bus.s_awready), 64'(1));
        chk("wready_after_reset", 64'(bus.s_wready), 64'(1));

        txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
        txn(32'h0000_07FC, 32'h1234_5678, 4'hF, 3, 0);
        txn(32'h0000_0800, 32'hA5A5_0001, 4'hF, 0, 0);
        txn(32'h0000_0002, 32'hA5A5_0002, 4'hF, -2, 1);
        txn(32'h0000_0000, 32'hA5A5_0003, 4'h3, 0, 0);
        txn(32'h0000_0120, 32'hCAFE_F00D, 4'hF, -1, 10);

        // Reset while the response is pending.
        bus.s_bready = 1'b0;
        send(32'h0000_0040, 32'h0BAD_CAFE, 4'hF, 0, cap);
        for (int k = 0; k < 20 && !bus.s_bvalid; k++) step();
        chk("pre_reset_bvalid", 64'(bus.s_bvalid), 64'(1));
        mem_model[16] = 32'h0BAD_CAFE;
        p0 = pulse_cnt;
        reset = 1'b1;
        step();
        model_reset();
        chk("reset_in_resp_bvalid", 64'(bus.s_bvalid), 64'(0));
        chk("reset_in_resp_mem_w", 64'(axi_mem_w), 64'(0));
        reset = 1'b0;
        step();
        chk("reset_in_resp_no_pulse", 64'(pulse_cnt - p0), 64'(0));

        // Reset right after only W has been captured.
        bus.s_wdata  = 32'hBAAD_F00D;
        bus.s_wstrb  = 4'hF;
        bus.s_wvalid = 1'b1;
        for (int k = 0; k < 10 && !bus.s_wready; k++) step();
        step();
        bus.s_wvalid = 1'b0;
        chk("w_held_wready", 64'(bus.s_wready), 64'(0));
        p0 = pulse_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_after_w_bvalid", 64'(bus.s_bvalid), 64'(0));
        step();
        chk("reset_after_w_wready", 64'(bus.s_wready), 64'(1));
        chk("reset_after_w_awready", 64'(bus.s_awready), 64'(1));
        for (int k = 0; k < 4; k++) step();
        chk("held_w_discarded", 64'(pulse_cnt - p0), 64'(0));
        txn(32'h0000_0044, 32'h600D_0001, 4'hF, -3, 2);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 6));
            case (sel)
                0, 1, 2: a = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
                3:       a = 32'((MEM_WORDS - 1) * 4);
                4:       a = 32'(MEM_WORDS * 4) + (32'($urandom_range(0, 4000)) << 2);
                5:       a = (32'($urandom_range(0, MEM_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
                default: a = $urandom;
            endcase
            d = $urandom;
            s = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            txn(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            chk($sformatf("mem_image[%0d]", i), 64'(mem_obs[i]), 64'(mem_model[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
